// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// State encoding, data width and select-field width helper.
package apb_arb_pkg;

  localparam int DATA_W = 32;

  // A field width of at least one bit keeps a single-slave build legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SEL_W = sel_width(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant.
// The caller owns the last_grant register and decides when it advances.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               grant_valid,
  output logic [GW-1:0]      grant_idx
);

  logic [GW-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master front-end: round-robin arbitration, address decode, SETUP/ACCESS sequencing.
// Optional ACCESS-phase watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            rsp_err,
  output logic [DATA_W-1:0]               PADDR,
  output logic [DATA_W-1:0]               PWDATA,
  output logic                            PWRITE,
  output logic [NUM_SLV-1:0]              PSEL,
  output logic                            PENABLE,
  input  logic [NUM_SLV-1:0][DATA_W-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]              PREADY
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = sel_width(NUM_SLV);

  apb_state_e          state;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       cur_grant;
  logic [SW-1:0]       slv_idx;
  logic                grant_valid;
  logic [GW-1:0]       grant_idx;
  logic [DATA_W-1:0]   acc_addr;
  logic [SW-1:0]       acc_sel;
  logic                dec_ok;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req         (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Address bits above the select field must be zero, so any region past the
  // last slave decodes as an error instead of aliasing onto a real slave.
  assign acc_addr = req_addr[grant_idx];
  assign acc_sel  = acc_addr[SEL_LSB +: SW];
  assign dec_ok   = ((acc_addr >> (SEL_LSB + SW)) == 32'd0) && (int'(acc_sel) < NUM_SLV);

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_valid) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state      <= IDLE;
      PSEL       <= '0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      last_grant <= GW'(NUM_REQ - 1);
      cur_grant  <= '0;
      slv_idx    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_idx;
            cur_grant  <= grant_idx;
            PADDR      <= acc_addr;
            PWDATA     <= req_wdata[grant_idx];
            PWRITE     <= req_write[grant_idx];
            slv_idx    <= acc_sel;
            if (dec_ok) begin
              PSEL  <= NUM_SLV'(1) << acc_sel;
              state <= SETUP;
            end else begin
              rsp_valid <= NUM_REQ'(1) << grant_idx;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins even on the cycle the watchdog would expire.
          if (PREADY[slv_idx]) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << cur_grant;
            rsp_rdata <= PRDATA[slv_idx];
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << cur_grant;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
